chip_cap_ctrl: RTL and testbench

- Capture sequencer for the 8-channel threshold-select path.
- Latches host threshold and frame length into the path's cfg_chip_th/cfg_len, and gates the path's buf_rdy handshake.
- Counts the samples the path emits after a trigger and marks frame boundaries for the downstream capture FIFO.
- Supports single-shot and continuous re-arm with a programmable holdoff, plus host abort with a clean drain of the path's locked window.

---
 rtl/chip_pkg.sv | 28 ++
 rtl/chip_holdoff_cnt.sv | 39 +++
 rtl/chip_cap_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_chip_cap_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/chip_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chip_pkg                                                      |
// | Purpose  : Shared types and constants for the capture sequencer of the   |
// |            8-channel threshold-select path.                              |
// | Contents : default widths, threshold-disable value, FSM state encoding.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package chip_pkg;

  localparam int LEN_W = 20;
  localparam int TH_W  = 16;

  // A threshold the path can never reach keeps it from triggering.
  localparam logic [15:0] TH_DISABLE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5,
    ST_FLUSH   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/chip_holdoff_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chip_holdoff_cnt                                              |
// | Purpose  : Loadable down-counter timing the idle gap between frames.     |
// | Ports    : clk, rst      - clock, synchronous active-high reset          |
// |            i_load        - load i_load_val into the counter              |
// |            i_load_val    - holdoff length in cycles                      |
// |            i_en          - count down one step                           |
// |            o_done        - last holdoff cycle (count <= 1)               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module chip_holdoff_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // A load of N yields N holdoff cycles; 0 and 1 both yield a single cycle.
  assign o_done = (r_cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/chip_cap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chip_cap_ctrl                                                 |
// | Purpose  : Capture sequencer for the 8-channel threshold-select path.    |
// |            Latches threshold/frame length, gates buf_rdy, counts the     |
// |            samples of a frame and marks sof/eof for the capture FIFO.    |
// | Ports    : clk_sys, rst            - clock, sync active-high reset       |
// |            host_arm/abort/cont     - host control                        |
// |            host_th/len/holdoff     - host configuration requests         |
// |            d1_vld, sel_path        - path output valid / channel         |
// |            fifo_afull              - downstream FIFO almost-full         |
// |            cfg_chip_th, cfg_len    - configuration to the path           |
// |            buf_rdy                 - ready to the path                   |
// |            buf_wr_en, frame_sof/eof- FIFO write strobe and frame marks   |
// |            frame_done/ch/cnt       - frame completion status             |
// |            busy, state_o           - debug status                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module chip_cap_ctrl #(
  parameter int LEN_W  = chip_pkg::LEN_W,
  parameter int TH_W   = chip_pkg::TH_W,
  parameter int HOLD_W = 16,
  parameter int FRM_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              host_arm,
  input  logic              host_abort,
  input  logic              host_cont,
  input  logic [TH_W-1:0]   host_th,
  input  logic [LEN_W-1:0]  host_len,
  input  logic [HOLD_W-1:0] host_holdoff,
  input  logic              d1_vld,
  input  logic [6:0]        sel_path,
  input  logic              fifo_afull,
  output logic [TH_W-1:0]   cfg_chip_th,
  output logic [LEN_W-1:0]  cfg_len,
  output logic              buf_rdy,
  output logic              buf_wr_en,
  output logic              frame_sof,
  output logic              frame_eof,
  output logic              frame_done,
  output logic [2:0]        frame_ch,
  output logic [FRM_W-1:0]  frame_cnt,
  output logic              busy,
  output logic [2:0]        state_o
);

  import chip_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TH_W-1:0]    r_cfg_th;
  logic [LEN_W-1:0]   r_cfg_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [FRM_W-1:0]   r_frame_cnt;
  logic [2:0]         r_frame_ch;
  logic               r_abort_pend;

  logic               w_rdy;
  logic               w_acc;
  logic               w_wr;
  logic               w_sof;
  logic               w_eof;
  logic               w_done;
  logic               w_abort_set;
  logic               w_hold_load;
  logic               w_hold_en;
  logic               w_hold_done;
  logic [LEN_W-1:0]   w_len_m1;

  // Only the low three bits select one of the eight channels.
  logic               w_unused_sel;
  assign w_unused_sel = ^sel_path[6:3];

  assign w_len_m1 = r_cfg_len - LEN_W'(1);

  chip_holdoff_cnt #(
    .W (HOLD_W)
  ) u_holdoff (
    .clk        (clk_sys),
    .rst        (rst),
    .i_load     (w_hold_load),
    .i_load_val (host_holdoff),
    .i_en       (w_hold_en),
    .o_done     (w_hold_done)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_acc       = 1'b0;
    w_wr        = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_done      = 1'b0;
    w_abort_set = 1'b0;
    w_hold_load = 1'b0;
    w_hold_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (host_arm) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = host_abort ? ST_IDLE : ST_ARMED;
      end
      ST_ARMED: begin
        w_rdy = ~fifo_afull;
        w_acc = d1_vld & w_rdy;
        w_wr  = w_acc;
        if (w_acc) begin
          // Once the first sample is accepted the frame has begun, so an
          // abort in the same cycle is treated like an abort in CAPTURE.
          w_sof = 1'b1;
          if (r_cfg_len == LEN_W'(1)) begin
            w_eof       = 1'b1;
            w_state_nxt = ST_DONE;
            w_abort_set = host_abort;
          end else begin
            w_state_nxt = host_abort ? ST_FLUSH : ST_CAPTURE;
          end
        end else if (host_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        w_rdy = ~fifo_afull;
        w_acc = d1_vld & w_rdy;
        w_wr  = w_acc;
        if (w_acc && (r_cnt == w_len_m1)) begin
          // eof beats a same-cycle abort; the abort is remembered for DONE.
          w_eof       = 1'b1;
          w_state_nxt = ST_DONE;
          w_abort_set = host_abort;
        end else if (host_abort) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_hold_load = 1'b1;
        if (r_abort_pend || host_abort || !host_cont) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (host_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hold_done) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_hold_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Accept and discard until the path's locked window is drained.
        w_rdy = 1'b1;
        w_acc = d1_vld;
        if (w_acc && (r_cnt >= w_len_m1)) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_cfg_th     <= TH_W'(TH_DISABLE);
      r_cfg_len    <= LEN_W'(1);
      r_cnt        <= '0;
      r_frame_cnt  <= '0;
      r_frame_ch   <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_cfg_th     <= host_th;
          r_cfg_len    <= (host_len == '0) ? LEN_W'(1) : host_len;
          r_cnt        <= '0;
          r_frame_cnt  <= '0;
          r_abort_pend <= 1'b0;
        end
        ST_ARMED: begin
          if (w_acc) begin
            r_cnt      <= LEN_W'(1);
            r_frame_ch <= sel_path[2:0];
          end
        end
        ST_CAPTURE, ST_FLUSH: begin
          if (w_acc) r_cnt <= r_cnt + LEN_W'(1);
        end
        ST_DONE: begin
          r_frame_cnt  <= r_frame_cnt + FRM_W'(1);
          r_abort_pend <= 1'b0;
        end
        ST_HOLDOFF: begin
          if (w_state_nxt == ST_ARMED) r_cnt <= '0;
        end
        default: ;
      endcase
      if (w_abort_set) r_abort_pend <= 1'b1;
    end
  end

  assign cfg_chip_th = r_cfg_th;
  assign cfg_len     = r_cfg_len;
  assign buf_rdy     = w_rdy;
  assign buf_wr_en   = w_wr;
  assign frame_sof   = w_sof;
  assign frame_eof   = w_eof;
  assign frame_done  = w_done;
  assign frame_ch    = r_frame_ch;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != ST_IDLE);
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_chip_cap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_chip_cap_ctrl                                              |
// | Purpose  : Directed, table-driven bench for chip_cap_ctrl plus hand      |
// |            sequences for abort-in-ARMED and reset mid-capture.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_chip_cap_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        host_arm = 1'b0;
  logic        host_abort = 1'b0;
  logic        host_cont = 1'b0;
  logic [15:0] host_th = '0;
  logic [19:0] host_len = '0;
  logic [15:0] host_holdoff = '0;
  logic        d1_vld = 1'b0;
  logic [6:0]  sel_path = '0;
  logic        fifo_afull = 1'b0;
  logic [15:0] cfg_chip_th;
  logic [19:0] cfg_len;
  logic        buf_rdy, buf_wr_en, frame_sof, frame_eof, frame_done, busy;
  logic [2:0]  frame_ch;
  logic [15:0] frame_cnt;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  chip_cap_ctrl dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .host_arm     (host_arm),
    .host_abort   (host_abort),
    .host_cont    (host_cont),
    .host_th      (host_th),
    .host_len     (host_len),
    .host_holdoff (host_holdoff),
    .d1_vld       (d1_vld),
    .sel_path     (sel_path),
    .fifo_afull   (fifo_afull),
    .cfg_chip_th  (cfg_chip_th),
    .cfg_len      (cfg_len),
    .buf_rdy      (buf_rdy),
    .buf_wr_en    (buf_wr_en),
    .frame_sof    (frame_sof),
    .frame_eof    (frame_eof),
    .frame_done   (frame_done),
    .frame_ch     (frame_ch),
    .frame_cnt    (frame_cnt),
    .busy         (busy),
    .state_o      (state_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] th;
    logic [19:0] len;
    logic        cont;
    logic [15:0] hold;
    logic [6:0]  ch;
    int          stall;
    int          abort_after;
    int          arm_mid;
    int          frames;
    int          e_wr;
    int          e_sof;
    int          e_eof;
    int          e_done;
    int          e_fcnt;
    logic [2:0]  e_ch;
    int          e_flush;
    int          e_stall;
    int          e_hold;
    logic [19:0] e_len;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   wr, sof, eof, dn, fl, st, hd, viol, cfgbad, win, stall_left;
    bit   aborted, armed_mid, stall_started, prev_eof, fin;
    v = vecs[k];
    wr = 0; sof = 0; eof = 0; dn = 0; fl = 0; st = 0; hd = 0;
    viol = 0; cfgbad = 0; win = 0; stall_left = 0;
    aborted = 0; armed_mid = 0; stall_started = 0; prev_eof = 0; fin = 0;
    host_th = v.th; host_len = v.len; host_holdoff = v.hold; sel_path = v.ch;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      tick();
      host_arm = (cyc == 0);
      if (v.arm_mid != 0 && !armed_mid && wr == v.arm_mid && state_o == 3'd3) begin
        host_arm  = 1'b1;
        armed_mid = 1'b1;
      end
      host_abort = (v.abort_after != 0) && !aborted && (wr == v.abort_after);
      if (host_abort) aborted = 1'b1;
      d1_vld     = !host_abort;
      fifo_afull = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      host_cont  = v.cont && (dn < v.frames - 1);
      #2;
      if (buf_wr_en) begin
        wr++;
        if (frame_sof) win = 1; else win++;
        if (!buf_rdy || !d1_vld) viol++;
      end
      if (frame_sof) begin
        sof++;
        if (!buf_wr_en) viol++;
      end
      if (frame_eof) begin
        eof++;
        if (!buf_wr_en || win != int'(v.e_len)) viol++;
      end
      if (frame_done) dn++;
      if (frame_done != prev_eof) viol++;
      prev_eof = frame_eof;
      if (state_o == 3'd6 && d1_vld && buf_rdy) begin
        fl++;
        if (buf_wr_en) viol++;
      end
      if (fifo_afull && state_o == 3'd3 && !buf_rdy) st++;
      if (state_o == 3'd5) begin
        if (buf_rdy) viol++; else hd++;
      end
      if (state_o >= 3'd2 && (cfg_chip_th !== v.th || cfg_len !== v.e_len)) cfgbad++;
      if (v.stall != 0 && wr == 2 && !stall_started) begin
        stall_left    = v.stall;
        stall_started = 1'b1;
      end
      if (cyc > 0 && state_o == 3'd0) fin = 1'b1;
    end
    host_arm = 0; host_abort = 0; d1_vld = 0; fifo_afull = 0; host_cont = 0;
    if (!fin) chk($sformatf("v%0d_timeout", k), 1, 0);
    chk($sformatf("v%0d_writes", k), wr, v.e_wr);
    chk($sformatf("v%0d_sof", k), sof, v.e_sof);
    chk($sformatf("v%0d_eof", k), eof, v.e_eof);
    chk($sformatf("v%0d_done", k), dn, v.e_done);
    chk($sformatf("v%0d_frame_cnt", k), frame_cnt, v.e_fcnt);
    chk($sformatf("v%0d_frame_ch", k), frame_ch, v.e_ch);
    chk($sformatf("v%0d_flushed", k), fl, v.e_flush);
    chk($sformatf("v%0d_stall_cycles", k), st, v.e_stall);
    chk($sformatf("v%0d_holdoff_cycles", k), hd, v.e_hold);
    chk($sformatf("v%0d_cfg_bad_cycles", k), cfgbad, 0);
    chk($sformatf("v%0d_seq_violations", k), viol, 0);
  endtask

  initial begin
    //            th      len    cont hold    ch     stl ab arm fr  wr sof eof dn fc  ch    fl st hd  len
    vecs[0] = '{16'd100, 20'd4, 1'b0, 16'd0,  7'h03, 0, 0, 0, 1,  4, 1, 1, 1, 1, 3'd3, 0, 0, 0,  20'd4};
    vecs[1] = '{16'd100, 20'd4, 1'b0, 16'd0,  7'h03, 5, 0, 0, 1,  4, 1, 1, 1, 1, 3'd3, 0, 5, 0,  20'd4};
    vecs[2] = '{16'd100, 20'd4, 1'b1, 16'd10, 7'h0D, 0, 0, 0, 2,  8, 2, 2, 2, 2, 3'd5, 0, 0, 10, 20'd4};
    vecs[3] = '{16'd100, 20'd8, 1'b0, 16'd0,  7'h03, 0, 3, 0, 1,  3, 1, 0, 0, 0, 3'd3, 5, 0, 0,  20'd8};
    vecs[4] = '{16'd200, 20'd0, 1'b0, 16'd0,  7'h06, 0, 0, 0, 1,  1, 1, 1, 1, 1, 3'd6, 0, 0, 0,  20'd1};
    vecs[5] = '{16'd300, 20'd2, 1'b1, 16'd0,  7'h71, 0, 0, 0, 2,  4, 2, 2, 2, 2, 3'd1, 0, 0, 1,  20'd2};
    vecs[6] = '{16'd100, 20'd4, 1'b0, 16'd0,  7'h02, 0, 0, 2, 1,  4, 1, 1, 1, 1, 3'd2, 0, 0, 0,  20'd4};

    // Reset values, sampled while reset is held.
    tick(); tick(); tick();
    #2;
    chk("rst_cfg_th", cfg_chip_th, 32'hFFFF);
    chk("rst_cfg_len", cfg_len, 1);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf_rdy", buf_rdy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_ch", frame_ch, 0);
    chk("rst_outs", {buf_wr_en, frame_sof, frame_eof, frame_done}, 0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Abort while ARMED (no sample yet) returns to IDLE; a later sample is not written.
    host_th = 16'd50; host_len = 20'd4; sel_path = 7'h03;
    tick(); host_arm = 1'b1; #2;
    tick(); host_arm = 1'b0; #2;
    chk("ab_load_state", state_o, 1);
    tick(); #2;
    chk("ab_armed_state", state_o, 2);
    chk("ab_armed_rdy", buf_rdy, 1);
    tick(); host_abort = 1'b1; #2;
    tick(); host_abort = 1'b0; d1_vld = 1'b1; #2;
    chk("ab_idle_state", state_o, 0);
    chk("ab_idle_busy", busy, 0);
    chk("ab_idle_wr", buf_wr_en, 0);
    d1_vld = 1'b0;

    // Synchronous reset in the middle of a capture.
    host_th = 16'h1234; host_len = 20'd8; sel_path = 7'h04;
    tick(); host_arm = 1'b1; #2;
    tick(); host_arm = 1'b0; d1_vld = 1'b1; #2;
    tick(); #2;
    tick(); #2;
    tick(); #2;
    chk("mr_pre_state", state_o, 3);
    chk("mr_pre_ch", frame_ch, 4);
    chk("mr_pre_th", cfg_chip_th, 32'h1234);
    rst = 1'b1;
    tick(); #2;
    chk("mr_cfg_th", cfg_chip_th, 32'hFFFF);
    chk("mr_cfg_len", cfg_len, 1);
    chk("mr_state", state_o, 0);
    chk("mr_busy", busy, 0);
    chk("mr_frame_ch", frame_ch, 0);
    chk("mr_outs", {buf_rdy, buf_wr_en, frame_sof, frame_eof, frame_done}, 0);
    rst = 1'b0; d1_vld = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
